// File: rtl/cluster_priority_encoder_pkg.sv
// Shared sizing and cluster word layout for the cluster priority encoder.
package cluster_priority_encoder_pkg;

   localparam int unsigned MXSBITS    = 768;
   localparam int unsigned MXSEGS     = 12;
   localparam int unsigned SEGSIZE    = 64;
   localparam int unsigned MXCLUSTERS = 8;
   localparam int unsigned MXADRB     = 10;

   localparam int unsigned SEGB  = $clog2(SEGSIZE);
   localparam int unsigned SEGIB = $clog2(MXSEGS);
   localparam int unsigned IDXB  = $clog2(MXCLUSTERS);

   typedef logic [MXADRB-1:0] adr_t;
   typedef logic [IDXB-1:0]   idx_t;
   typedef logic [SEGB-1:0]   pos_t;
   typedef logic [SEGIB-1:0]  seg_t;

   typedef struct packed {
      logic vld;
      idx_t idx;
      adr_t adr;
   } cluster_word_t;

endpackage

// File: rtl/cluster_priority_encoder_segment_encoder64.sv
// Combinational lowest-set-bit encoder over one 64-bit segment.
module segment_encoder64
   import cluster_priority_encoder_pkg::*;
(
   input  logic [SEGSIZE-1:0] bits,
   output logic               any,
   output pos_t               pos
);

   always_comb begin
      any = |bits;
      pos = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int unsigned i = SEGSIZE; i > 0; i--) begin
         if (bits[i-1]) pos = pos_t'(i-1);
      end
   end

endmodule

// File: rtl/cluster_priority_encoder.sv
// Three-stage pipelined lowest-set-bit encoder reading the truncated VPF vector
// and emitting one fixed-length frame of MXCLUSTERS cluster words.
module cluster_priority_encoder
   import cluster_priority_encoder_pkg::*;
(
   input  logic               clock,
   input  logic               global_reset,
   input  logic               frame_start,
   input  logic [MXSBITS-1:0] vpfs_in,
   output adr_t               cluster_adr,
   output logic               cluster_vld,
   output idx_t               cluster_idx,
   output logic               frame_first,
   output logic               frame_done,
   output logic               overflow
);

   localparam idx_t LAST_SLOT = idx_t'(MXCLUSTERS-1);

   logic [MXSEGS-1:0] seg_any_c, seg_any_r;
   pos_t              seg_pos_c [MXSEGS];
   pos_t              seg_pos_r [MXSEGS];

   for (genvar s = 0; s < MXSEGS; s++) begin : g_seg
      segment_encoder64 u_seg (
         .bits (vpfs_in[s*SEGSIZE +: SEGSIZE]),
         .any  (seg_any_c[s]),
         .pos  (seg_pos_c[s])
      );
   end

   // next_slot holds the slot number of the following cycle; frame_start forces slot 0 now.
   idx_t next_slot;
   logic in_frame;
   idx_t cur_slot;
   logic cur_inf;

   always_comb begin
      cur_slot = frame_start ? '0 : next_slot;
      cur_inf  = frame_start | in_frame;
   end

   idx_t s1_idx;
   logic s1_inf;
   logic any_rest;

   cluster_word_t s2_next, s2_word;
   logic          s2_first, s2_last;
   seg_t          hit_seg;
   pos_t          hit_pos;

   always_comb begin
      hit_seg = '0;
      hit_pos = '0;
      for (int unsigned s = MXSEGS; s > 0; s--) begin
         if (seg_any_r[s-1]) begin
            hit_seg = seg_t'(s-1);
            hit_pos = seg_pos_r[s-1];
         end
      end
      s2_next.vld = s1_inf & (|seg_any_r);
      s2_next.idx = s1_inf ? s1_idx : '0;
      s2_next.adr = s2_next.vld ? {hit_seg, hit_pos} : '0;
   end

   always_ff @(posedge clock) begin
      if (global_reset) begin
         next_slot   <= '0;
         in_frame    <= 1'b0;
         seg_any_r   <= '0;
         for (int unsigned s = 0; s < MXSEGS; s++) seg_pos_r[s] <= '0;
         s1_idx      <= '0;
         s1_inf      <= 1'b0;
         any_rest    <= 1'b0;
         s2_word     <= '0;
         s2_first    <= 1'b0;
         s2_last     <= 1'b0;
         cluster_adr <= '0;
         cluster_vld <= 1'b0;
         cluster_idx <= '0;
         frame_first <= 1'b0;
         frame_done  <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (frame_start) begin
            next_slot <= idx_t'(1);
            in_frame  <= 1'b1;
         end else if (in_frame) begin
            if (next_slot == LAST_SLOT) in_frame <= 1'b0;
            else                        next_slot <= next_slot + 1'b1;
         end

         seg_any_r <= seg_any_c;
         seg_pos_r <= seg_pos_c;
         s1_idx    <= cur_slot;
         s1_inf    <= cur_inf;
         any_rest  <= |vpfs_in;

         s2_word  <= s2_next;
         s2_first <= s1_inf & (s1_idx == '0);
         s2_last  <= s1_inf & (s1_idx == LAST_SLOT);

         // any_rest now holds the vector one cycle after the last slot.
         cluster_adr <= s2_word.adr;
         cluster_vld <= s2_word.vld;
         cluster_idx <= s2_word.idx;
         frame_first <= s2_first;
         frame_done  <= s2_last;
         overflow    <= s2_last & any_rest;
      end
   end

endmodule

// File: tb/tb_cluster_priority_encoder.sv
// Randomized and directed bench for cluster_priority_encoder against a frame-level reference model.
module tb_cluster_priority_encoder;

   localparam int NB   = 768;
   localparam int MAXC = 4096;

   logic          clock = 1'b0;
   logic          global_reset = 1'b1;
   logic          frame_start = 1'b0;
   logic [NB-1:0] vpfs_in = '0;
   logic [9:0]    cluster_adr;
   logic          cluster_vld;
   logic [2:0]    cluster_idx;
   logic          frame_first, frame_done, overflow;

   cluster_priority_encoder dut (
      .clock        (clock),
      .global_reset (global_reset),
      .frame_start  (frame_start),
      .vpfs_in      (vpfs_in),
      .cluster_adr  (cluster_adr),
      .cluster_vld  (cluster_vld),
      .cluster_idx  (cluster_idx),
      .frame_first  (frame_first),
      .frame_done   (frame_done),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic          rst_h [MAXC];
   logic          fs_h  [MAXC];
   logic [NB-1:0] vec_h [MAXC];

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int lowest(input logic [NB-1:0] v);
      for (int i = 0; i < NB; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Slot of cycle c: distance back to the most recent frame_start, within 8 cycles and unbroken by reset.
   function automatic bit slot_of(input int c, output int slot);
      slot = 0;
      for (int d = 0; d < 8; d++) begin
         if (c - d < 0) return 0;
         if (rst_h[c-d]) return 0;
         if (fs_h[c-d]) begin
            slot = d;
            return 1;
         end
      end
      return 0;
   endfunction

   task automatic check_cycle(input int k);
      bit zero;
      bit inf;
      int slot;
      int c;
      int e_adr, e_vld, e_idx, e_first, e_done, e_ovf;
      if (k < 1) return;
      zero = 0;
      for (int j = k - 3; j < k; j++) if (j >= 0 && rst_h[j]) zero = 1;
      c = k - 3;
      e_adr = 0; e_vld = 0; e_idx = 0; e_first = 0; e_done = 0; e_ovf = 0;
      if (!zero && c >= 0) begin
         inf = slot_of(c, slot);
         if (inf) begin
            e_vld   = (vec_h[c] != '0) ? 1 : 0;
            e_adr   = e_vld ? lowest(vec_h[c]) : 0;
            e_idx   = slot;
            e_first = (slot == 0) ? 1 : 0;
            e_done  = (slot == 7) ? 1 : 0;
            e_ovf   = (e_done == 1 && vec_h[c+1] != '0) ? 1 : 0;
         end
      end
      check_val("cluster_vld", int'(cluster_vld), e_vld);
      check_val("cluster_adr", int'(cluster_adr), e_adr);
      check_val("cluster_idx", int'(cluster_idx), e_idx);
      check_val("frame_first", int'(frame_first), e_first);
      check_val("frame_done",  int'(frame_done),  e_done);
      check_val("overflow",    int'(overflow),    e_ovf);
   endtask

   task automatic step(input logic r, input logic f, input logic [NB-1:0] v);
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      @(posedge clock);
      #1;
      global_reset = r;
      frame_start  = f;
      vpfs_in      = v;
      rst_h[cyc]   = r;
      fs_h[cyc]    = f;
      vec_h[cyc]   = v;
      @(negedge clock);
      check_cycle(cyc);
      cyc++;
   endtask

   // Present a frame as the truncator would: each cycle clears the lowest set bit.
   task automatic run_frame(input logic [NB-1:0] v0, input int n);
      logic [NB-1:0] v;
      v = v0;
      for (int i = 0; i < n; i++) begin
         step(1'b0, i == 0, v);
         v = v & (v - 1'b1);
      end
   endtask

   function automatic logic [NB-1:0] bits4(input int a, input int b, input int c, input int d);
      logic [NB-1:0] v;
      v = '0;
      v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1; v[d] = 1'b1;
      return v;
   endfunction

   function automatic logic [NB-1:0] rand_vec(input int n);
      logic [NB-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[$urandom_range(NB-1, 0)] = 1'b1;
      return v;
   endfunction

   logic [NB-1:0] v;

   initial begin
      repeat (3) step(1'b1, 1'b0, '0);
      repeat (3) step(1'b0, 1'b0, '0);

      // Out of frame: bit 300 present, no frame_start since reset.
      v = '0; v[300] = 1'b1;
      repeat (5) step(1'b0, 1'b0, v);
      repeat (3) step(1'b0, 1'b0, '0);

      // Single hit at bit 0.
      v = '0; v[0] = 1'b1;
      run_frame(v, 9);
      repeat (3) step(1'b0, 1'b0, '0);

      // Boundary addresses.
      run_frame(bits4(767, 64, 63, 700), 9);
      repeat (3) step(1'b0, 1'b0, '0);

      // Overflow: ten hits, only the first eight emitted.
      v = bits4(5, 17, 100, 200) | bits4(300, 400, 500, 600);
      v[650] = 1'b1; v[760] = 1'b1;
      run_frame(v, 9);
      repeat (3) step(1'b0, 1'b0, '0);

      // Back-to-back frames.
      v = '0; v[12] = 1'b1;
      run_frame(v, 8);
      v = '0; v[513] = 1'b1;
      run_frame(v, 9);
      repeat (3) step(1'b0, 1'b0, '0);

      // Mid-frame restart at T+3.
      run_frame(rand_vec(6), 3);
      run_frame(rand_vec(6), 9);
      repeat (3) step(1'b0, 1'b0, '0);

      // Restart at T+3 then reset at T+5; outputs stay quiet until a new frame.
      run_frame(rand_vec(6), 3);
      run_frame(rand_vec(6), 2);
      step(1'b1, 1'b0, rand_vec(4));
      repeat (6) step(1'b0, 1'b0, rand_vec(4));
      run_frame(rand_vec(3), 9);

      // Random frames with gaps, early restarts, noise and occasional reset.
      repeat (30) begin
         repeat ($urandom_range(2, 0)) step(1'b0, 1'b0, rand_vec($urandom_range(3, 0)));
         if ($urandom_range(9, 0) == 0) step(1'b1, $urandom_range(1, 0) == 1, rand_vec(2));
         run_frame(rand_vec($urandom_range(12, 0)), $urandom_range(10, 3));
      end
      repeat (5) step(1'b0, 1'b0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
